// File: rtl/ecc_pkg.sv
//============================================================================
// Module      : ecc_pkg
// Description : Shared types and constants for the ECC encoder front end:
//               mode encoding, per-mode info/parity widths, in-flight tag
//               layout and scheduler FSM states.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package ecc_pkg;

    // Encoder mode as seen on the encoder mode input
    typedef enum logic [1:0] {
        MOD_8_4     = 2'b00,
        MOD_16_11   = 2'b01,
        MOD_32_26   = 2'b10,
        MOD_ILLEGAL = 2'b11
    } mode_t;

    // Info bits per mode
    localparam int c_INFO_W_8_4   = 4;
    localparam int c_INFO_W_16_11 = 11;
    localparam int c_INFO_W_32_26 = 26;

    // Parity bits per mode
    localparam int c_PAR_W_8_4    = 4;
    localparam int c_PAR_W_16_11  = 5;
    localparam int c_PAR_W_32_26  = 6;

    // Tag travelling alongside a word through the encoder pipeline
    typedef struct packed {
        logic  valid;
        logic  id;
        mode_t mod;
    } tag_t;

    // Scheduler pause/drain states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_PAUSED = 2'd2
    } sched_state_t;

    // A mode the encoder can actually process
    function automatic logic is_legal(input mode_t m);
        return (m != MOD_ILLEGAL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_sched_fifo.sv
//============================================================================
// Module      : ecc_sched_fifo
// Description : Parameterised synchronous FIFO (circular buffer with
//               wrap-around pointers) with occupancy count. Head entry is
//               presented combinationally.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ecc_sched_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && !full;

    // Storage and write pointer; wraps explicitly so DEPTH need not be 2^n
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
        end
    end

    // Read pointer advances on every accepted pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Upstream credit accounting must make an overflowing push impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

`default_nettype wire

// File: rtl/ecc_enc_sched.sv
//============================================================================
// Module      : ecc_enc_sched
// Description : Shares a free-running two-stage ECC encoder between two
//               requesters. Round-robin arbitration, credit-checked issue,
//               latency-aligned tag pipe, output FIFO and a pause/drain FSM.
//               Optional statistics counters: ECC_ENC_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ecc_enc_sched #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int PIPE_LAT           = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef ECC_ENC_SCHED_STATS_EN
    input  logic                            stat_clr,
    output logic [31:0]                     stat_issued,
    output logic [7:0]                      stat_illegal,
    output logic [15:0]                     stat_stall,
`endif
    input  logic [1:0]                      req_valid,
    output logic [1:0]                      req_ready,
    input  logic [2*MAX_INFO_WIDTH-1:0]     req_data,
    input  logic [3:0]                      req_mod,
    input  logic                            pause_req,
    output logic                            paused,
    output logic [MAX_INFO_WIDTH-1:0]       enc_data_in,
    output logic [1:0]                      enc_mod,
    input  logic [MAX_CODEWORD_WIDTH-1:0]   enc_data_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0]   out_data,
    output logic                            out_id,
    output logic [1:0]                      out_mod,
    output logic                            err_mode
);

    import ecc_pkg::*;

    localparam int c_INF_W   = $clog2(PIPE_LAT + 1);
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENTRY_W = 1 + 2 + MAX_CODEWORD_WIDTH;

    sched_state_t                r_state;
    sched_state_t                w_state_nxt;
    tag_t                        r_tag [PIPE_LAT];
    tag_t                        w_tag_in;
    logic                        r_rr_ptr;
    logic                        r_err_mode;
    logic [c_INF_W-1:0]          w_inflight;
    logic [c_CNT_W-1:0]          w_fifo_count;
    logic                        w_fifo_empty;
    logic                        w_fifo_full;
    logic                        w_credit_ok;
    logic                        w_can_issue;
    logic [1:0]                  w_grant;
    logic                        w_any_grant;
    logic                        w_winner;
    logic [MAX_INFO_WIDTH-1:0]   w_win_data;
    mode_t                       w_win_mod;
    logic                        w_issue;
    logic                        w_illegal;
    logic                        w_push;
    logic                        w_pop;
    logic [c_ENTRY_W-1:0]        w_push_entry;
    logic [c_ENTRY_W-1:0]        w_head_entry;

    // Count words currently travelling through the encoder
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            w_inflight = w_inflight + c_INF_W'(r_tag[i].valid);
        end
    end

    // Every issued word already owns a FIFO slot, so it can never be dropped
    assign w_credit_ok = (32'(w_fifo_count) + 32'(w_inflight)) < 32'(FIFO_DEPTH);
    assign w_can_issue = !rst && (r_state == ST_RUN) && !pause_req && w_credit_ok;

    // Round-robin grant; a lone requester wins regardless of the pointer
    always_comb begin
        w_grant  = 2'b00;
        w_winner = 1'b0;
        if (w_can_issue) begin
            case (req_valid)
                2'b01: begin
                    w_grant  = 2'b01;
                    w_winner = 1'b0;
                end
                2'b10: begin
                    w_grant  = 2'b10;
                    w_winner = 1'b1;
                end
                2'b11: begin
                    w_winner = r_rr_ptr;
                    w_grant  = r_rr_ptr ? 2'b10 : 2'b01;
                end
                default: begin
                    w_grant  = 2'b00;
                    w_winner = 1'b0;
                end
            endcase
        end
    end

    assign w_any_grant = |w_grant;
    assign req_ready   = w_grant;
    assign w_win_data  = w_winner ? req_data[2*MAX_INFO_WIDTH-1:MAX_INFO_WIDTH]
                                  : req_data[MAX_INFO_WIDTH-1:0];
    assign w_win_mod   = mode_t'(w_winner ? req_mod[3:2] : req_mod[1:0]);
    assign w_issue     = w_any_grant && is_legal(w_win_mod);
    assign w_illegal   = w_any_grant && !is_legal(w_win_mod);

    // Encoder sees zeros in the illegal mode whenever nothing legal is issued
    always_comb begin
        enc_data_in    = '0;
        enc_mod        = MOD_ILLEGAL;
        w_tag_in       = '0;
        if (w_issue) begin
            enc_data_in    = w_win_data;
            enc_mod        = w_win_mod;
            w_tag_in.valid = 1'b1;
            w_tag_in.id    = w_winner;
            w_tag_in.mod   = w_win_mod;
        end
    end

    // Tag pipe mirrors the encoder latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Pointer favours the requester that lost (or did not take) the last grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_any_grant) begin
            r_rr_ptr <= ~w_winner;
        end
    end

    // Illegal-mode requests are consumed and flagged one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_mode <= 1'b0;
        end else begin
            r_err_mode <= w_illegal;
        end
    end

    assign err_mode = r_err_mode;

    // Finished codeword lands in the FIFO when its tag reaches the last stage
    assign w_push       = r_tag[PIPE_LAT-1].valid;
    assign w_push_entry = {r_tag[PIPE_LAT-1].id, r_tag[PIPE_LAT-1].mod, enc_data_out};
    assign w_pop        = out_valid && out_ready;

    ecc_sched_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head_entry),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    assign out_valid = !w_fifo_empty;
    assign out_data  = out_valid ? w_head_entry[MAX_CODEWORD_WIDTH-1:0] : '0;
    assign out_mod   = out_valid ? w_head_entry[MAX_CODEWORD_WIDTH+1:MAX_CODEWORD_WIDTH] : 2'b00;
    assign out_id    = out_valid ? w_head_entry[c_ENTRY_W-1] : 1'b0;

    // Pause/drain state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pause/drain next state: drain waits for the encoder pipe to empty
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (pause_req) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pause_req)             w_state_nxt = ST_RUN;
                else if (w_inflight == '0)  w_state_nxt = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (!pause_req) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign paused = (r_state == ST_PAUSED);

`ifdef ECC_ENC_SCHED_STATS_EN
    logic [15:0] r_stat_issued0;
    logic [15:0] r_stat_issued1;
    logic [7:0]  r_stat_illegal;
    logic [15:0] r_stat_stall;

    // Saturating usage counters with synchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued0 <= '0;
            r_stat_issued1 <= '0;
            r_stat_illegal <= '0;
            r_stat_stall   <= '0;
        end else if (stat_clr) begin
            r_stat_issued0 <= '0;
            r_stat_issued1 <= '0;
            r_stat_illegal <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_issue && !w_winner && (r_stat_issued0 != 16'hFFFF))
                r_stat_issued0 <= r_stat_issued0 + 16'd1;
            if (w_issue && w_winner && (r_stat_issued1 != 16'hFFFF))
                r_stat_issued1 <= r_stat_issued1 + 16'd1;
            if (w_illegal && (r_stat_illegal != 8'hFF))
                r_stat_illegal <= r_stat_illegal + 8'd1;
            if ((req_valid != 2'b00) && !w_any_grant && (r_stat_stall != 16'hFFFF))
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign stat_issued  = {r_stat_issued1, r_stat_issued0};
    assign stat_illegal = r_stat_illegal;
    assign stat_stall   = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ecc_enc_sched.sv
//============================================================================
// Module      : tb_ecc_enc_sched
// Description : Directed self-checking bench for ecc_enc_sched with a
//               two-stage encoder stand-in.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ecc_enc_sched;

    localparam int CW = 32;
    localparam int IW = 26;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*IW-1:0] req_data;
    logic [3:0]      req_mod;
    logic            pause_req;
    logic            paused;
    logic [IW-1:0]   enc_data_in;
    logic [1:0]      enc_mod;
    logic [CW-1:0]   enc_data_out;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_data;
    logic            out_id;
    logic [1:0]      out_mod;
    logic            err_mode;
`ifdef ECC_ENC_SCHED_STATS_EN
    logic            stat_clr = 1'b0;
    logic [31:0]     stat_issued;
    logic [7:0]      stat_illegal;
    logic [15:0]     stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ecc_enc_sched #(
        .MAX_CODEWORD_WIDTH (CW),
        .MAX_INFO_WIDTH     (IW),
        .PIPE_LAT           (2),
        .FIFO_DEPTH         (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ECC_ENC_SCHED_STATS_EN
        .stat_clr     (stat_clr),
        .stat_issued  (stat_issued),
        .stat_illegal (stat_illegal),
        .stat_stall   (stat_stall),
`endif
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_mod      (req_mod),
        .pause_req    (pause_req),
        .paused       (paused),
        .enc_data_in  (enc_data_in),
        .enc_mod      (enc_mod),
        .enc_data_out (enc_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id),
        .out_mod      (out_mod),
        .err_mode     (err_mode)
    );

    always #5 clk = ~clk;

    // Stand-in encoder: recognisable codeword, zeros in the illegal mode
    function automatic logic [CW-1:0] enc_f(input logic [IW-1:0] d, input logic [1:0] m);
        if (m == 2'b11) return '0;
        return {{4{^d}}, m, d};
    endfunction

    logic [CW-1:0] enc_s1;
    logic [CW-1:0] enc_s2;
    always @(posedge clk) begin
        enc_s1 <= enc_f(enc_data_in, enc_mod);
        enc_s2 <= enc_s1;
    end
    assign enc_data_out = enc_s2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid = 2'b00;
        req_data  = '0;
        req_mod   = 4'b0000;
        pause_req = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        req_valid = 2'b11;
        #1;
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_tests++; if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused: got %b expected 0", paused); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_tests++; if (out_id !== 1'b0 || out_mod !== 2'b00) begin n_fail++; $display("FAIL reset_out_id_mod: got %b/%b expected 0/00", out_id, out_mod); end
        n_tests++; if (err_mode !== 1'b0) begin n_fail++; $display("FAIL reset_err_mode: got %b expected 0", err_mode); end
        n_tests++; if (enc_data_in !== 26'h0) begin n_fail++; $display("FAIL reset_enc_data_in: got %h expected 0", enc_data_in); end
        n_tests++; if (enc_mod !== 2'b11) begin n_fail++; $display("FAIL reset_enc_mod: got %b expected 11", enc_mod); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_held: got valid=%b ready=%b expected 0/00", out_valid, req_ready); end
        rst = 1'b0;
        req_valid = 2'b00;
    endtask

    task automatic test_single;
        do_reset();
        req_valid = 2'b01;
        req_data  = '0;
        req_mod   = 4'b0000;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", req_ready); end
        n_tests++; if (enc_mod !== 2'b00) begin n_fail++; $display("FAIL single_enc_mod: got %b expected 00", enc_mod); end
        tick();
        req_valid = 2'b00;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_t1: got %b expected 0", out_valid); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_t2: got %b expected 0", out_valid); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_lat_t3: got %b expected 1", out_valid); end
        n_tests++; if (out_data !== 32'h0 || out_id !== 1'b0 || out_mod !== 2'b00) begin n_fail++; $display("FAIL single_head: got %h/%b/%b expected 0/0/00", out_data, out_id, out_mod); end
        tick();
    endtask

    task automatic test_alternate;
        logic [IW-1:0] d0;
        logic [IW-1:0] d1;
        logic [1:0]    m0;
        logic [1:0]    m1;
        logic          eid;
        logic [CW-1:0] exp_data;
        logic          exp_v;
        d0 = 26'h0AAAAAA; m0 = 2'b10;
        d1 = 26'h1555555; m1 = 2'b01;
        do_reset();
        req_data  = {d1, d0};
        req_mod   = {m1, m0};
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 8) ? 2'b11 : 2'b00;
            #1;
            if (c < 8) begin
                n_tests++; if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL alt_grant c=%0d: got %b expected %b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10); end
            end
            exp_v = (c >= 3) && (c < 11);
            n_tests++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL alt_out_valid c=%0d: got %b expected %b", c, out_valid, exp_v); end
            if (exp_v) begin
                eid      = ((c - 3) % 2) == 1;
                exp_data = eid ? enc_f(d1, m1) : enc_f(d0, m0);
                n_tests++; if (out_id !== eid || out_data !== exp_data) begin n_fail++; $display("FAIL alt_out c=%0d: got id=%b data=%h expected id=%b data=%h", c, out_id, out_data, eid, exp_data); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        logic [IW-1:0] acc;
        do_reset();
        out_ready = 1'b0;
        req_mod   = 4'b0010;
        acc       = '0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 2'b01;
            req_data  = {26'h0, 26'h10 + acc};
            #1;
            n_tests++; if (req_ready !== ((c < 4) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, req_ready, (c < 4) ? 2'b01 : 2'b00); end
            if (c < 4) acc = acc + 26'd1;
            tick();
        end
        req_valid = 2'b00;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++; if (out_valid !== 1'b1 || out_data !== enc_f(26'h10 + IW'(k), 2'b10) || out_id !== 1'b0) begin n_fail++; $display("FAIL bp_drain k=%0d: got v=%b data=%h id=%b expected 1/%h/0", k, out_valid, out_data, out_id, enc_f(26'h10 + IW'(k), 2'b10)); end
            tick();
        end
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
        tick();
    endtask

    task automatic test_illegal;
        do_reset();
        req_valid = 2'b10;
        req_data  = {26'h3FFFFFF, 26'h0};
        req_mod   = 4'b1100;
        #1;
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL ill_grant: got %b expected 10", req_ready); end
        n_tests++; if (enc_mod !== 2'b11 || enc_data_in !== 26'h0) begin n_fail++; $display("FAIL ill_enc: got %b/%h expected 11/0", enc_mod, enc_data_in); end
        n_tests++; if (err_mode !== 1'b0) begin n_fail++; $display("FAIL ill_err_early: got %b expected 0", err_mode); end
        tick();
        req_valid = 2'b01;
        req_data  = {26'h3FFFFFF, 26'h55};
        req_mod   = 4'b1101;
        #1;
        n_tests++; if (err_mode !== 1'b1) begin n_fail++; $display("FAIL ill_err_pulse: got %b expected 1", err_mode); end
        n_tests++; if (req_ready !== 2'b01 || enc_mod !== 2'b01) begin n_fail++; $display("FAIL ill_next_grant: got %b/%b expected 01/01", req_ready, enc_mod); end
        tick();
        req_valid = 2'b00;
        #1;
        n_tests++; if (err_mode !== 1'b0) begin n_fail++; $display("FAIL ill_err_clear: got %b expected 0", err_mode); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_c2_valid: got %b expected 0", out_valid); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_no_entry: got %b expected 0", out_valid); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_id !== 1'b0 || out_mod !== 2'b01 || out_data !== enc_f(26'h55, 2'b01)) begin n_fail++; $display("FAIL ill_legal_out: got v=%b id=%b mod=%b data=%h expected 1/0/01/%h", out_valid, out_id, out_mod, out_data, enc_f(26'h55, 2'b01)); end
        tick();
    endtask

    task automatic test_pause;
        logic [7:0] exp_ready;
        logic [7:0] exp_paused;
        logic [7:0] exp_ov;
        exp_ready  = 8'b1000_0011;
        exp_paused = 8'b0110_0000;
        exp_ov     = 8'b0001_1000;
        do_reset();
        req_data  = {26'h0, 26'h77};
        req_mod   = 4'b0010;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_valid = 2'b01;
            pause_req = (c >= 2) && (c < 6);
            #1;
            n_tests++; if (req_ready[0] !== exp_ready[c]) begin n_fail++; $display("FAIL pause_ready c=%0d: got %b expected %b", c, req_ready[0], exp_ready[c]); end
            n_tests++; if (paused !== exp_paused[c]) begin n_fail++; $display("FAIL pause_paused c=%0d: got %b expected %b", c, paused, exp_paused[c]); end
            n_tests++; if (out_valid !== exp_ov[c]) begin n_fail++; $display("FAIL pause_out_valid c=%0d: got %b expected %b", c, out_valid, exp_ov[c]); end
            if (exp_ov[c]) begin
                n_tests++; if (out_data !== enc_f(26'h77, 2'b10)) begin n_fail++; $display("FAIL pause_out_data c=%0d: got %h expected %h", c, out_data, enc_f(26'h77, 2'b10)); end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset;
        do_reset();
        req_data  = {26'h0, 26'h3C};
        req_mod   = 4'b0010;
        out_ready = 1'b1;
        req_valid = 2'b01;
        repeat (4) tick();
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b expected 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (req_ready !== 2'b00 || out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL ar_outputs: got ready=%b v=%b data=%h expected 00/0/0", req_ready, out_valid, out_data); end
        n_tests++; if (enc_mod !== 2'b11 || enc_data_in !== 26'h0 || err_mode !== 1'b0 || paused !== 1'b0) begin n_fail++; $display("FAIL ar_enc: got mod=%b din=%h err=%b p=%b expected 11/0/0/0", enc_mod, enc_data_in, err_mode, paused); end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_data  = {26'h0, 26'h2B};
        req_mod   = 4'b0001;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ar_regrant: got %b expected 01", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_lat_t1: got %b expected 0", out_valid); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_lat_t2: got %b expected 0", out_valid); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_data !== enc_f(26'h2B, 2'b01)) begin n_fail++; $display("FAIL ar_first_word: got v=%b data=%h expected 1/%h", out_valid, out_data, enc_f(26'h2B, 2'b01)); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_illegal();
        test_pause();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ecc_enc_sched.md
Name: ecc_enc_sched

Overview:
- Front-end controller that shares the free-running two-stage ECC encoder pipeline (stage 1 followed by stage 2) between two requesters.
- Arbitrates between the requesters round-robin and drives the encoder's info word and mode inputs.
- Tracks in-flight words with a tag shift register aligned to the encoder latency.
- Lands finished codewords in an output FIFO, using a credit check so that no in-flight result is ever dropped under backpressure.
- Also provides a pause/drain state machine for mode reconfiguration.

Parameters:
- MAX_CODEWORD_WIDTH, 32, codeword width returned by the encoder.
- MAX_INFO_WIDTH, 26, info word width driven into the encoder.
- PIPE_LAT, 2, clock cycles from encoder input to a valid encoder output.
- FIFO_DEPTH, 4, output FIFO entries; must be >= PIPE_LAT+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept, combinational.
- req_data  in  2x MAX_INFO_WIDTH  per-requester info word.
- req_mod  in  2x2  per-requester mode: 00=(8,4), 01=(16,11), 10=(32,26), 11=illegal.
- pause_req  in  1  request to quiesce the encoder.
- paused  out  1  high while in the PAUSED state.
- enc_data_in  out  MAX_INFO_WIDTH  info word to encoder stage 1.
- enc_mod  out  2  mode to encoder stage 1 and stage 2.
- enc_data_out  in  MAX_CODEWORD_WIDTH  codeword from encoder stage 2.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accept.
- out_data  out  MAX_CODEWORD_WIDTH  codeword at FIFO head.
- out_id  out  1  requester that issued the head entry.
- out_mod  out  2  mode of the head entry.
- err_mode  out  1  one-cycle pulse when an illegal-mode request is consumed.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: req_ready=0, paused=0, out_valid=0, out_data=0, out_id=0, out_mod=0, err_mode=0, enc_data_in=0, enc_mod=2'b11. Also cleared: tag pipe, FIFO, round-robin pointer (favours requester 0), FSM=RUN.
- Credit rule: issue is allowed iff fifo_count + inflight_count < FIFO_DEPTH, and FSM=RUN.
- Arbitration: round-robin among the asserted req_valid bits.
  - The winner gets req_ready=1 in the same cycle; at most one grant per cycle.
  - The pointer moves to the non-winner after each grant.
  - If only one requester is valid, it wins regardless of the pointer.
- Issue: on a grant with a legal mode, enc_data_in/enc_mod take the winner's req_data/req_mod combinationally.
  - Tag {valid=1, id, mod} enters tag pipe stage 0.
- Idle or blocked cycles: enc_mod=2'b11 and enc_data_in=0, so the encoder emits zeros; the tag enters with valid=0.
- Illegal mode (11): the request is granted and consumed.
  - No tag is issued, nothing reaches the encoder, and err_mode pulses in the following cycle.
- Tag pipe: PIPE_LAT registers.
  - When the tag at stage PIPE_LAT-1 is valid, {id, mod, enc_data_out} is written to the FIFO at that clock edge.
- Latency: accept at cycle T gives out_valid at T+PIPE_LAT+1 when the FIFO is empty.
- Throughput: 1 word per cycle while out_ready=1.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - out_* are driven from the head entry.
  - Pop happens on out_valid & out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Push when full is impossible by the credit rule; this is an assertion.
- Ordering: codewords leave the FIFO in issue order across both requesters.
- FSM:
  - RUN: pause_req=1 goes to DRAIN and issue stops that cycle.
  - DRAIN: stays until inflight_count=0, then goes to PAUSED.
  - PAUSED: paused=1 and the FIFO keeps draining; pause_req=0 returns to RUN.
  - pause_req deasserted while in DRAIN goes directly to RUN.
- Reset mid-operation discards all in-flight words and FIFO contents.

Optional Feature:
- Macro: ECC_ENC_SCHED_STATS_EN.
- When defined, adds the following outputs:
  - stat_issued  2x16  per-requester issue counts, saturating at 16'hFFFF.
  - stat_illegal  8  illegal-mode count, saturating.
  - stat_stall  16  count of cycles with req_valid!=0 but no grant.
  - stat_clr  input, 1  synchronous clear of all three counters.
- All counters reset to 0 on rst.
- When not defined: no counter ports and no counter logic.

Decomposition:
- Shared package ecc_pkg holds:
  - mode typedef enum: MOD_8_4, MOD_16_11, MOD_32_26, MOD_ILLEGAL.
  - Info/parity width constants 4/11/26 and 4/5/6.
  - Tag struct {valid, id, mod}.
- One sub-module: ecc_sched_fifo, a parameterised synchronous FIFO with count output, instantiated for the output buffer.

Test Plan:
- Single request, req 0, mod=00, data=4'h0 accepted at cycle 1 -> out_valid at cycle 4 with out_data=32'h0, out_id=0, out_mod=00.
- Both requesters valid continuously, out_ready=1 -> grants alternate 0,1,0,1; one codeword per cycle; out_id alternates; no gaps.
- out_ready=0 with req 0 streaming -> exactly FIFO_DEPTH words accepted, then req_ready=0. Release out_ready -> all 4 words exit in order, none lost.
- req 1 mod=11 -> granted in 1 cycle, err_mode pulse next cycle, no FIFO entry; a following legal request is unaffected.
- pause_req asserted with 2 words in flight -> DRAIN for 2 cycles, then paused=1, both words reach the FIFO, no new grants; deassert -> RUN resumes.
- Assert rst asynchronously mid-stream -> all outputs at reset values immediately; after release, the first accepted word emerges at PIPE_LAT+1 cycles.
